qa_drv_mem_req_buffer: RTL and testbench

- Client-side request stage directly upstream of the QA memory driver.
- Buffers client read and write requests in small FIFOs and issues them to the driver only while the driver reports ready, so the driver's "not ready" fatal assertions can never fire.
- Tracks outstanding writes using the driver's per-cycle write-ACK count (0..2), caps them at a limit, and implements a write fence that completes only when every write accepted before the fence has been acknowledged.

---
 rtl/qa_drv_mem_req_buffer.sv | 236 +++++++++++++++++++++++
 tb/tb_qa_drv_mem_req_buffer.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qa_drv_mem_req_buffer.sv
// ---------------------------------------------------------------------------
// qa_drv_mem_req_buffer
//
// Client-side request stage in front of the QA memory driver. Read and write
// requests are buffered in small FIFOs and issued only while the driver is
// ready. Writes issued but not yet acknowledged are counted (capped at
// MAX_WRITES), and a write fence completes once every write accepted up to
// and including the fence cycle has been acknowledged.
//
// Optional feature macro: QA_DRV_MEM_REQ_BUF_STATS_EN
//   defined   -> o_stat_* are live 32-bit wrapping counters
//   undefined -> o_stat_* are tied to 0 and no counter logic exists
//
// Ports:
//   clk, reset_n                 clock, synchronous active-low reset
//   i_rd_* / o_rd_ready          client read request channel
//   i_wr_* / o_wr_ready          client write request channel
//   i_fence_valid, o_fence_ready fence request handshake
//   o_fence_done                 one-cycle pulse when the fence completes
//   o_drv_read_req_*             read issue to driver, i_drv_read_req_rdy
//   o_drv_write_*                write issue to driver, i_drv_write_rdy
//   i_drv_write_ack              writes completed this cycle (0..2)
//   o_wr_outstanding             writes issued but not yet acked
//   o_ack_underflow_err          sticky: ack arrived with nothing in flight
//   o_stat_rd_issued/_wr_issued/_wr_stall  statistics counters
// ---------------------------------------------------------------------------
module qa_drv_mem_req_buffer #(
    parameter int ADDR_BITS     = 58,
    parameter int DATA_BITS     = 512,
    parameter int RD_FIFO_DEPTH = 4,
    parameter int WR_FIFO_DEPTH = 4,
    parameter int MAX_WRITES    = 64
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_rd_valid,
    input  logic [ADDR_BITS-1:0] i_rd_addr,
    input  logic                 i_rd_cached,
    input  logic                 i_rd_check_order,
    output logic                 o_rd_ready,
    input  logic                 i_wr_valid,
    input  logic [ADDR_BITS-1:0] i_wr_addr,
    input  logic [DATA_BITS-1:0] i_wr_data,
    input  logic                 i_wr_cached,
    input  logic                 i_wr_check_order,
    output logic                 o_wr_ready,
    input  logic                 i_fence_valid,
    output logic                 o_fence_ready,
    output logic                 o_fence_done,
    output logic [ADDR_BITS-1:0] o_drv_read_req_addr,
    output logic                 o_drv_read_req_cached,
    output logic                 o_drv_read_req_check_order,
    output logic                 o_drv_read_req_enable,
    input  logic                 i_drv_read_req_rdy,
    output logic [ADDR_BITS-1:0] o_drv_write_addr,
    output logic [DATA_BITS-1:0] o_drv_write_data,
    output logic                 o_drv_write_cached,
    output logic                 o_drv_write_check_order,
    output logic                 o_drv_write_enable,
    input  logic                 i_drv_write_rdy,
    input  logic [1:0]           i_drv_write_ack,
    output logic [7:0]           o_wr_outstanding,
    output logic                 o_ack_underflow_err,
    output logic [31:0]          o_stat_rd_issued,
    output logic [31:0]          o_stat_wr_issued,
    output logic [31:0]          o_stat_wr_stall
);

    localparam int RD_PTR_W = $clog2(RD_FIFO_DEPTH);
    localparam int WR_PTR_W = $clog2(WR_FIFO_DEPTH);
    localparam int RD_CNT_W = RD_PTR_W + 1;
    localparam int WR_CNT_W = WR_PTR_W + 1;
    localparam int RD_ENT_W = ADDR_BITS + 2;
    localparam int WR_ENT_W = ADDR_BITS + DATA_BITS + 2;

    typedef enum logic [1:0] {FENCE_IDLE, FENCE_DRAIN, FENCE_DONE} fence_state_t;

    // ---------------- read FIFO ----------------
    logic [RD_ENT_W-1:0] r_rd_mem [RD_FIFO_DEPTH];
    logic [RD_PTR_W-1:0] r_rd_wptr, r_rd_rptr;
    logic [RD_CNT_W-1:0] r_rd_count, w_rd_count_next;
    logic                r_rd_ready;
    logic [RD_ENT_W-1:0] w_rd_in, w_rd_head;
    logic                w_rd_push, w_rd_pop;

    assign w_rd_in   = {i_rd_addr, i_rd_cached, i_rd_check_order};
    assign w_rd_push = i_rd_valid & r_rd_ready;
    // An empty FIFO forwards the incoming request so the issue lands one
    // cycle after the client push.
    assign w_rd_pop  = ((r_rd_count != '0) | w_rd_push) & i_drv_read_req_rdy;
    assign w_rd_head = (r_rd_count == '0) ? w_rd_in : r_rd_mem[r_rd_rptr];
    assign w_rd_count_next = r_rd_count + RD_CNT_W'(w_rd_push) - RD_CNT_W'(w_rd_pop);

    // NOTE: storage arrays carry no reset; the count/pointers define validity,
    // which keeps them mappable to plain RAM/flops without reset muxes.
    always_ff @(posedge clk) begin
        if (w_rd_push) r_rd_mem[r_rd_wptr] <= w_rd_in;
    end

    // ---------------- write FIFO ----------------
    logic [WR_ENT_W-1:0] r_wr_mem [WR_FIFO_DEPTH];
    logic [WR_PTR_W-1:0] r_wr_wptr, r_wr_rptr;
    logic [WR_CNT_W-1:0] r_wr_count, w_wr_count_next;
    logic                r_wr_ready;
    logic [WR_ENT_W-1:0] w_wr_in, w_wr_head;
    logic                w_wr_push, w_wr_issue;
    logic [7:0]          r_wr_out, w_wr_out_next;
    logic                r_underflow, w_underflow;
    logic [8:0]          w_wr_sum;

    assign w_wr_in    = {i_wr_addr, i_wr_data, i_wr_cached, i_wr_check_order};
    assign w_wr_push  = i_wr_valid & r_wr_ready;
    // Issue is gated by the registered count, so an ack arriving while at the
    // cap only unblocks issue on the following cycle.
    assign w_wr_issue = ((r_wr_count != '0) | w_wr_push) & i_drv_write_rdy
                        & (r_wr_out < 8'(MAX_WRITES));
    assign w_wr_head  = (r_wr_count == '0) ? w_wr_in : r_wr_mem[r_wr_rptr];
    assign w_wr_count_next = r_wr_count + WR_CNT_W'(w_wr_push) - WR_CNT_W'(w_wr_issue);

    always_ff @(posedge clk) begin
        if (w_wr_push) r_wr_mem[r_wr_wptr] <= w_wr_in;
    end

    // Outstanding count in 9 bits; an ack exceeding the count clamps to 0.
    assign w_wr_sum      = {1'b0, r_wr_out} + 9'(w_wr_issue);
    assign w_underflow   = (w_wr_sum < 9'(i_drv_write_ack));
    assign w_wr_out_next = w_underflow ? 8'd0 : 8'(w_wr_sum - 9'(i_drv_write_ack));

    // ---------------- fence FSM ----------------
    fence_state_t r_fence_state, w_fence_next;
    logic         r_fence_ready;
    logic         w_fence_accept;

    assign w_fence_accept = i_fence_valid & r_fence_ready;

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_fence_next = r_fence_state;
        o_fence_done = 1'b0;
        case (r_fence_state)
            FENCE_IDLE:  if (w_fence_accept) w_fence_next = FENCE_DRAIN;
            // Next-cycle values let an ack that drains the last write this
            // cycle complete the fence immediately.
            FENCE_DRAIN: if (w_wr_count_next == '0 && w_wr_out_next == 8'd0)
                             w_fence_next = FENCE_DONE;
            FENCE_DONE: begin
                o_fence_done = 1'b1;
                w_fence_next = FENCE_IDLE;
            end
            default:     w_fence_next = FENCE_IDLE;
        endcase
    end

    // ---------------- state registers ----------------
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update from the same pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rd_wptr      <= '0;
            r_rd_rptr      <= '0;
            r_rd_count     <= '0;
            r_wr_wptr      <= '0;
            r_wr_rptr      <= '0;
            r_wr_count     <= '0;
            r_wr_out       <= '0;
            r_underflow    <= 1'b0;
            r_fence_state  <= FENCE_IDLE;
            r_rd_ready     <= 1'b0;
            r_wr_ready     <= 1'b0;
            r_fence_ready  <= 1'b0;
            o_drv_read_req_enable      <= 1'b0;
            o_drv_read_req_addr        <= '0;
            o_drv_read_req_cached      <= 1'b0;
            o_drv_read_req_check_order <= 1'b0;
            o_drv_write_enable         <= 1'b0;
            o_drv_write_addr           <= '0;
            o_drv_write_data           <= '0;
            o_drv_write_cached         <= 1'b0;
            o_drv_write_check_order    <= 1'b0;
        end else begin
            if (w_rd_push) r_rd_wptr <= r_rd_wptr + 1'b1;
            if (w_rd_pop)  r_rd_rptr <= r_rd_rptr + 1'b1;
            r_rd_count <= w_rd_count_next;
            if (w_wr_push)  r_wr_wptr <= r_wr_wptr + 1'b1;
            if (w_wr_issue) r_wr_rptr <= r_wr_rptr + 1'b1;
            r_wr_count    <= w_wr_count_next;
            r_wr_out      <= w_wr_out_next;
            r_underflow   <= r_underflow | w_underflow;
            r_fence_state <= w_fence_next;
            r_rd_ready    <= (w_rd_count_next != RD_CNT_W'(RD_FIFO_DEPTH));
            r_wr_ready    <= (w_wr_count_next != WR_CNT_W'(WR_FIFO_DEPTH))
                             && (w_fence_next == FENCE_IDLE);
            r_fence_ready <= (w_fence_next == FENCE_IDLE);
            o_drv_read_req_enable <= w_rd_pop;
            if (w_rd_pop)
                {o_drv_read_req_addr, o_drv_read_req_cached,
                 o_drv_read_req_check_order} <= w_rd_head;
            o_drv_write_enable <= w_wr_issue;
            if (w_wr_issue)
                {o_drv_write_addr, o_drv_write_data, o_drv_write_cached,
                 o_drv_write_check_order} <= w_wr_head;
        end
    end

    assign o_rd_ready          = r_rd_ready;
    assign o_wr_ready          = r_wr_ready;
    assign o_fence_ready       = r_fence_ready;
    assign o_wr_outstanding    = r_wr_out;
    assign o_ack_underflow_err = r_underflow;

    // ---------------- optional statistics ----------------
`ifdef QA_DRV_MEM_REQ_BUF_STATS_EN
    logic [31:0] r_stat_rd, r_stat_wr, r_stat_stall;
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_stat_rd    <= '0;
            r_stat_wr    <= '0;
            r_stat_stall <= '0;
        end else begin
            if (w_rd_pop)   r_stat_rd <= r_stat_rd + 32'd1;
            if (w_wr_issue) r_stat_wr <= r_stat_wr + 32'd1;
            // Stall: entries already buffered but nothing issued this cycle.
            if ((r_wr_count != '0) && !w_wr_issue) r_stat_stall <= r_stat_stall + 32'd1;
        end
    end
    assign o_stat_rd_issued = r_stat_rd;
    assign o_stat_wr_issued = r_stat_wr;
    assign o_stat_wr_stall  = r_stat_stall;
`else
    assign o_stat_rd_issued = '0;
    assign o_stat_wr_issued = '0;
    assign o_stat_wr_stall  = '0;
`endif

endmodule

// File: tb/tb_qa_drv_mem_req_buffer.sv
// ---------------------------------------------------------------------------
// tb_qa_drv_mem_req_buffer
//
// Self-checking bench for qa_drv_mem_req_buffer (MAX_WRITES overridden to 4
// so the write cap is exercised often). A transaction-level reference model
// built from queues and an integer outstanding count predicts every output
// each cycle; directed scenarios add explicit expectations on top.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_qa_drv_mem_req_buffer;

    localparam int AW   = 58;
    localparam int DW   = 512;
    localparam int RDD  = 4;
    localparam int WRD  = 4;
    localparam int MAXW = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          rd_valid, rd_cached, rd_order;
    logic [AW-1:0] rd_addr;
    logic          wr_valid, wr_cached, wr_order;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          fence_valid;
    logic          drv_rd_rdy, drv_wr_rdy;
    logic [1:0]    drv_ack;

    logic          o_rd_ready, o_wr_ready, o_fence_ready, o_fence_done;
    logic [AW-1:0] o_rd_addr, o_wr_addr;
    logic [DW-1:0] o_wr_data;
    logic          o_rd_cached, o_rd_order, o_rd_en;
    logic          o_wr_cached, o_wr_order, o_wr_en;
    logic [7:0]    o_out;
    logic          o_err;
    logic [31:0]   o_st_rd, o_st_wr, o_st_stall;

    always #5 clk = ~clk;

    qa_drv_mem_req_buffer #(
        .ADDR_BITS(AW), .DATA_BITS(DW), .RD_FIFO_DEPTH(RDD),
        .WR_FIFO_DEPTH(WRD), .MAX_WRITES(MAXW)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .i_rd_valid(rd_valid), .i_rd_addr(rd_addr), .i_rd_cached(rd_cached),
        .i_rd_check_order(rd_order), .o_rd_ready(o_rd_ready),
        .i_wr_valid(wr_valid), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .i_wr_cached(wr_cached), .i_wr_check_order(wr_order), .o_wr_ready(o_wr_ready),
        .i_fence_valid(fence_valid), .o_fence_ready(o_fence_ready), .o_fence_done(o_fence_done),
        .o_drv_read_req_addr(o_rd_addr), .o_drv_read_req_cached(o_rd_cached),
        .o_drv_read_req_check_order(o_rd_order), .o_drv_read_req_enable(o_rd_en),
        .i_drv_read_req_rdy(drv_rd_rdy),
        .o_drv_write_addr(o_wr_addr), .o_drv_write_data(o_wr_data),
        .o_drv_write_cached(o_wr_cached), .o_drv_write_check_order(o_wr_order),
        .o_drv_write_enable(o_wr_en), .i_drv_write_rdy(drv_wr_rdy),
        .i_drv_write_ack(drv_ack), .o_wr_outstanding(o_out),
        .o_ack_underflow_err(o_err),
        .o_stat_rd_issued(o_st_rd), .o_stat_wr_issued(o_st_wr), .o_stat_wr_stall(o_st_stall)
    );

    // ---------------- reference model ----------------
    typedef struct { logic [AW-1:0] addr; logic cached; logic order; } rd_req_t;
    typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; logic cached; logic order; } wr_req_t;

    rd_req_t rd_q[$];
    wr_req_t wr_q[$];
    rd_req_t m_rd_item;
    wr_req_t m_wr_item;
    logic    m_rd_en, m_wr_en, m_rd_ready, m_wr_ready, m_fence_ready, m_err;
    int      m_out;
    int      m_fence;      // 0 idle, 1 waiting for drain, 2 completion pulse
    int unsigned m_st_rd, m_st_wr, m_st_stall;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        rd_q.delete();
        wr_q.delete();
        m_rd_item = '{default: '0};
        m_wr_item = '{default: '0};
        m_rd_en = 0; m_wr_en = 0;
        m_rd_ready = 0; m_wr_ready = 0; m_fence_ready = 0;
        m_err = 0; m_out = 0; m_fence = 0;
        m_st_rd = 0; m_st_wr = 0; m_st_stall = 0;
    endtask

    // One clock edge of behaviour, from the inputs presented this cycle.
    task automatic model_update();
        int  pre_wr;
        int  n;
        bit  issued;
        bit  accept;
        if (!reset_n) begin
            model_clear();
            return;
        end
        pre_wr = wr_q.size();
        accept = fence_valid && m_fence_ready;
        if (rd_valid && m_rd_ready) rd_q.push_back('{rd_addr, rd_cached, rd_order});
        m_rd_en = 0;
        if (rd_q.size() > 0 && drv_rd_rdy) begin
            m_rd_item = rd_q.pop_front();
            m_rd_en = 1;
            m_st_rd++;
        end
        if (wr_valid && m_wr_ready) wr_q.push_back('{wr_addr, wr_data, wr_cached, wr_order});
        issued = 0;
        if (wr_q.size() > 0 && drv_wr_rdy && m_out < MAXW) begin
            m_wr_item = wr_q.pop_front();
            issued = 1;
            m_st_wr++;
        end
        m_wr_en = issued;
        if (pre_wr > 0 && !issued) m_st_stall++;
        n = m_out + int'(issued) - int'(drv_ack);
        if (n < 0) begin
            n = 0;
            m_err = 1;
        end
        m_out = n;
        case (m_fence)
            0: if (accept) m_fence = 1;
            1: if (wr_q.size() == 0 && m_out == 0) m_fence = 2;
            default: m_fence = 0;
        endcase
        m_rd_ready    = rd_q.size() < RDD;
        m_wr_ready    = (wr_q.size() < WRD) && (m_fence == 0);
        m_fence_ready = (m_fence == 0);
    endtask

    task automatic compare();
        check("rd_ready", o_rd_ready, m_rd_ready);
        check("wr_ready", o_wr_ready, m_wr_ready);
        check("fence_ready", o_fence_ready, m_fence_ready);
        check("fence_done", o_fence_done, m_fence == 2);
        check("rd_en", o_rd_en, m_rd_en);
        check("rd_addr", o_rd_addr, m_rd_item.addr);
        check("rd_cached", o_rd_cached, m_rd_item.cached);
        check("rd_order", o_rd_order, m_rd_item.order);
        check("wr_en", o_wr_en, m_wr_en);
        check("wr_addr", o_wr_addr, m_wr_item.addr);
        check("wr_data", o_wr_data, m_wr_item.data);
        check("wr_cached", o_wr_cached, m_wr_item.cached);
        check("wr_order", o_wr_order, m_wr_item.order);
        check("outstanding", o_out, m_out);
        check("underflow_err", o_err, m_err);
`ifdef QA_DRV_MEM_REQ_BUF_STATS_EN
        check("stat_rd", o_st_rd, m_st_rd);
        check("stat_wr", o_st_wr, m_st_wr);
        check("stat_stall", o_st_stall, m_st_stall);
`else
        check("stat_rd", o_st_rd, 0);
        check("stat_wr", o_st_wr, 0);
        check("stat_stall", o_st_stall, 0);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        compare();
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        return {$urandom, $urandom};
    endfunction

    task automatic idle_inputs();
        rd_valid = 0; rd_addr = '0; rd_cached = 0; rd_order = 0;
        wr_valid = 0; wr_addr = '0; wr_data = '0; wr_cached = 0; wr_order = 0;
        fence_valid = 0; drv_rd_rdy = 0; drv_wr_rdy = 0; drv_ack = 0;
    endtask

    task automatic push_write();
        wr_valid = 1; wr_addr = rand_addr(); wr_data = rand_data();
        wr_cached = 1'($urandom); wr_order = 1'($urandom);
    endtask

    initial begin
        int cyc;
        int amax;
        model_clear();
        idle_inputs();
        reset_n = 0;
        repeat (3) step();
        check("rst_rd_ready", o_rd_ready, 0);
        check("rst_fence_ready", o_fence_ready, 0);
        reset_n = 1;
        step();
        check("post_rst_ready", {o_rd_ready, o_wr_ready, o_fence_ready}, 3'b111);

        // Single read, minimum latency.
        rd_valid = 1; rd_addr = 58'h100; rd_cached = 1; drv_rd_rdy = 1;
        step();
        rd_valid = 0;
        check("rd1_en", o_rd_en, 1);
        check("rd1_addr", o_rd_addr, 58'h100);
        check("rd1_cached", o_rd_cached, 1);
        check("rd1_ready", o_rd_ready, 1);
        step();
        check("rd1_en_once", o_rd_en, 0);

        // Five writes against a stalled driver: four fit.
        for (int i = 0; i < 5; i++) begin
            push_write();
            step();
            if (i == 3) check("wr_full_ready", o_wr_ready, 0);
        end
        wr_valid = 0; drv_wr_rdy = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("wr_burst_en", o_wr_en, 1);
        end
        check("wr_out_4", o_out, 4);

        // Cap reached: fifth write stays queued until acks arrive.
        push_write();
        step();
        wr_valid = 0;
        step();
        check("cap_block", o_wr_en, 0);
        drv_ack = 2;
        step();
        drv_ack = 0;
        check("cap_ack_out", o_out, 2);
        check("cap_ack_no_issue", o_wr_en, 0);
        step();
        check("cap_release_en", o_wr_en, 1);
        check("cap_release_out", o_out, 3);

        // Fence with three writes in flight.
        fence_valid = 1;
        step();
        fence_valid = 0;
        check("fence_wr_ready", o_wr_ready, 0);
        drv_ack = 2;
        step();
        check("fence_wait", o_fence_done, 0);
        drv_ack = 1;
        step();
        drv_ack = 0;
        check("fence_done_pulse", o_fence_done, 1);
        check("fence_out_0", o_out, 0);
        step();
        check("fence_done_clear", o_fence_done, 0);
        check("fence_wr_ready_back", o_wr_ready, 1);

        // Randomised traffic with legal acks.
        for (int c = 0; c < 3000; c++) begin
            rd_valid = ($urandom_range(0, 9) < 6);
            rd_addr = rand_addr(); rd_cached = 1'($urandom); rd_order = 1'($urandom);
            if ($urandom_range(0, 1) == 1) push_write(); else wr_valid = 0;
            fence_valid = ($urandom_range(0, 29) == 0);
            drv_rd_rdy = ($urandom_range(0, 9) < 7);
            drv_wr_rdy = ($urandom_range(0, 9) < 7);
            amax = (m_out < 2) ? m_out : 2;
            drv_ack = ($urandom_range(0, 1) == 1) ? 2'($urandom_range(0, amax)) : 2'd0;
            step();
        end

        // Drain everything.
        idle_inputs();
        drv_rd_rdy = 1; drv_wr_rdy = 1;
        cyc = 0;
        while ((rd_q.size() != 0 || wr_q.size() != 0 || m_out != 0 || m_fence != 0) && cyc < 200) begin
            drv_ack = 2'((m_out < 2) ? m_out : 2);
            step();
            cyc++;
        end
        drv_ack = 0;
        check("drain_done", cyc < 200, 1);
        step();

        // Ack with nothing in flight.
        drv_ack = 1;
        step();
        drv_ack = 0;
        check("uf_err", o_err, 1);
        check("uf_out", o_out, 0);
        repeat (3) step();
        check("uf_sticky", o_err, 1);

        // Reset with two reads queued.
        drv_rd_rdy = 0;
        rd_valid = 1; rd_addr = rand_addr();
        step();
        rd_addr = rand_addr();
        step();
        rd_valid = 0;
        reset_n = 0;
        repeat (2) step();
        check("rst_mid_en", o_rd_en, 0);
        check("rst_mid_addr", o_rd_addr, 0);
        reset_n = 1; drv_rd_rdy = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_no_replay", o_rd_en, 0);
        end
        check("rst_err_clear", o_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
